pipeline_hazard_ctrl: RTL

- Hazard controller for the 5-stage pipeline (F/D/E/M/W).
- Keeps its own shadow copy of per-stage hazard metadata: register addresses, RegWrite, MemtoReg and PC-write.
- From that copy it generates the forwarding selects for the E-stage source operands, the F/D stall signals, the D/E flush signals, and saturating stall/flush event counters.
- Sits beside the datapath and drives the stage-register enables/clears and the E-stage forwarding muxes.

---
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage F/D/E/M/W pipeline. It shadows the E/M/W hazard metadata and
// drives the E-stage forwarding selects, the F/D stall and D/E flush controls, and event counters.
module pipeline_hazard_ctrl #(
    parameter int                REG_AW = 4,
    parameter logic [REG_AW-1:0] PC_REG = {REG_AW{1'b1}},
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] ra1_d,
    input  logic [REG_AW-1:0] ra2_d,
    input  logic [REG_AW-1:0] wa3_d,
    input  logic              reg_write_d,
    input  logic              mem_to_reg_d,
    input  logic              pc_src_d,
    input  logic              cond_ok_e,
    input  logic              branch_taken_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [REG_AW-1:0] e_ra1_reg, e_ra2_reg, e_wa3_reg, m_wa3_reg, w_wa3_reg;
    logic              e_rw_reg, e_m2r_reg, e_pcs_reg;
    logic              m_rw_reg, m_pcs_reg;
    logic              w_rw_reg, w_pcs_reg;
    logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;

    logic [1:0][REG_AW-1:0] src_e;
    logic [1:0][1:0]        fwd_sel;
    logic                   ldr_stall, pc_pending;
    logic                   stall_f_int, flush_e_int, flush_d_int;
    logic                   e_bubble;

    assign src_e = {e_ra2_reg, e_ra1_reg};

    // One forwarding selector per E-stage source operand; the younger M result wins over W.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic [1:0] sel;
            always_comb begin
                sel = 2'b00;
                if (src_e[gi] != PC_REG) begin
                    if (m_rw_reg && (m_wa3_reg == src_e[gi])) begin
                        sel = 2'b10;
                    end else if (w_rw_reg && (w_wa3_reg == src_e[gi])) begin
                        sel = 2'b01;
                    end
                end
            end
            assign fwd_sel[gi] = sel;
        end
    endgenerate

    assign ldr_stall = d_valid & e_m2r_reg & e_rw_reg &
                       (((ra1_d == e_wa3_reg) && (ra1_d != PC_REG)) ||
                        ((ra2_d == e_wa3_reg) && (ra2_d != PC_REG)));
    assign pc_pending  = (d_valid & pc_src_d) | e_pcs_reg | m_pcs_reg;
    assign stall_f_int = ldr_stall | pc_pending;
    assign flush_d_int = pc_pending | w_pcs_reg | branch_taken_e;
    assign flush_e_int = ldr_stall | branch_taken_e;
    assign e_bubble    = flush_e_int | ~d_valid;

    // D inputs and branch_taken_e feed the outputs directly, so reset must mask them explicitly.
    assign forward_a_e = reset ? 2'b00 : fwd_sel[0];
    assign forward_b_e = reset ? 2'b00 : fwd_sel[1];
    assign stall_f     = ~reset & stall_f_int;
    assign stall_d     = ~reset & ldr_stall;
    assign flush_d     = ~reset & flush_d_int;
    assign flush_e     = ~reset & flush_e_int;
    assign stall_cnt   = stall_cnt_reg;
    assign flush_cnt   = flush_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_ra1_reg <= '0;
            e_ra2_reg <= '0;
            e_wa3_reg <= '0;
            e_rw_reg  <= 1'b0;
            e_m2r_reg <= 1'b0;
            e_pcs_reg <= 1'b0;
            m_wa3_reg <= '0;
            m_rw_reg  <= 1'b0;
            m_pcs_reg <= 1'b0;
            w_wa3_reg <= '0;
            w_rw_reg  <= 1'b0;
            w_pcs_reg <= 1'b0;
        end else begin
            if (e_bubble) begin
                e_ra1_reg <= '0;
                e_ra2_reg <= '0;
                e_wa3_reg <= '0;
                e_rw_reg  <= 1'b0;
                e_m2r_reg <= 1'b0;
                e_pcs_reg <= 1'b0;
            end else begin
                e_ra1_reg <= ra1_d;
                e_ra2_reg <= ra2_d;
                e_wa3_reg <= wa3_d;
                e_rw_reg  <= reg_write_d;
                e_m2r_reg <= mem_to_reg_d;
                e_pcs_reg <= pc_src_d;
            end
            m_wa3_reg <= e_wa3_reg;
            m_rw_reg  <= e_rw_reg & cond_ok_e;
            m_pcs_reg <= e_pcs_reg & cond_ok_e;
            w_wa3_reg <= m_wa3_reg;
            w_rw_reg  <= m_rw_reg;
            w_pcs_reg <= m_pcs_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_f_int && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (flush_e_int && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule
